// File: rtl/cond_exec_controller.sv
// EX-stage conditional-execution sequencer: owns the {Z,C,N,V} status register,
// gates commits, raises branch flushes and keeps saturating exec/squash counters.
module cond_exec_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             valid,
  input  logic [3:0]       cond,
  input  logic             s_bit,
  input  logic             is_branch,
  input  logic [3:0]       alu_status,
  output logic             exec_en,
  output logic             branch_taken,
  output logic             flush,
  output logic [3:0]       sr_out,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] squash_count
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Flag vector layout is {Z,C,N,V}: f[3]=Z, f[2]=C, f[1]=N, f[0]=V.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, v;
    z  = f[3];
    cy = f[2];
    n  = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cy;
      4'b0011: cond_pass = ~cy;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cy & ~z;
      4'b1001: cond_pass = ~cy | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       sr_q, sr_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic             pass_s;
  logic             exec_en_s;
  logic             branch_s;

  // Commit decision, FSM next state, flag update and counter next values.
  always_comb begin
    pass_s    = cond_pass(cond, sr_q);
    exec_en_s = valid & pass_s & ~freeze & (state_q == S_IDLE);
    branch_s  = exec_en_s & is_branch;
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    exec_d    = exec_q;
    squash_d  = squash_q;

    if (freeze) begin
      state_d = state_q;
    end else begin
      if (exec_en_s && s_bit) begin
        sr_d = alu_status;
      end else begin
        sr_d = sr_q;
      end

      case (state_q)
        S_IDLE: begin
          if (branch_s) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FLUSH: begin
          if (cnt_q == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase

      // exec_en and the squash condition are mutually exclusive by construction.
      if (exec_en_s && (exec_q != CNT_MAX)) begin
        exec_d = exec_q + CNT_ONE;
      end else begin
        exec_d = exec_q;
      end

      if (valid && !exec_en_s && (squash_q != CNT_MAX)) begin
        squash_d = squash_q + CNT_ONE;
      end else begin
        squash_d = squash_q;
      end
    end
  end

  // State register with synchronous reset taking priority over freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      sr_q     <= 4'd0;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  assign exec_en      = exec_en_s;
  assign branch_taken = branch_s;
  assign flush        = branch_s | (state_q == S_FLUSH);
  assign sr_out       = sr_q;
  assign exec_count   = exec_q;
  assign squash_count = squash_q;

endmodule

// File: tb/tb_cond_exec_controller.sv
// Directed self-checking bench for cond_exec_controller (FLUSH_CYCLES=2, CNT_W=4).
module tb_cond_exec_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze;
  logic       valid;
  logic [3:0] cond;
  logic       s_bit;
  logic       is_branch;
  logic [3:0] alu_status;
  logic       exec_en;
  logic       branch_taken;
  logic       flush;
  logic [3:0] sr_out;
  logic [3:0] exec_count;
  logic [3:0] squash_count;

  int tests_run = 0;
  int tests_failed = 0;

  cond_exec_controller #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .valid(valid), .cond(cond),
    .s_bit(s_bit), .is_branch(is_branch), .alu_status(alu_status),
    .exec_en(exec_en), .branch_taken(branch_taken), .flush(flush),
    .sr_out(sr_out), .exec_count(exec_count), .squash_count(squash_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic s,
                       input logic b, input logic [3:0] a);
    valid      = v;
    cond       = c;
    s_bit      = s;
    is_branch  = b;
    alu_status = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0;
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_sr", 16'(sr_out), 16'h0);
    chk("reset_flush", 16'(flush), 16'h0);
    chk("reset_exec_cnt", 16'(exec_count), 16'h0);
    chk("reset_squash_cnt", 16'(squash_count), 16'h0);

    // Test 1: SUBS AL, then MOVEQ / MOVNE
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b1000);
    chk("subs_exec_en", 16'(exec_en), 16'h1);
    chk("subs_no_branch", 16'(branch_taken), 16'h0);
    tick();
    chk("subs_sr", 16'(sr_out), 16'h8);
    chk("subs_exec_cnt", 16'(exec_count), 16'h1);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("moveq_exec_en", 16'(exec_en), 16'h1);
    tick();
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000);
    chk("movne_exec_en", 16'(exec_en), 16'h0);
    tick();
    chk("movne_squash_cnt", 16'(squash_count), 16'h1);
    chk("movne_exec_cnt", 16'(exec_count), 16'h2);

    // Test 2: condition decode on sr=0110 and sr=0011
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0110);
    tick();
    chk("sr_0110", 16'(sr_out), 16'h6);
    drive(1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000);
    chk("ls_fail", 16'(exec_en), 16'h0);
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000);
    chk("hi_pass", 16'(exec_en), 16'h1);
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0011);
    tick();
    chk("sr_0011", 16'(sr_out), 16'h3);
    drive(1'b1, 4'b1010, 1'b0, 1'b0, 4'b0000);
    chk("ge_pass", 16'(exec_en), 16'h1);
    drive(1'b1, 4'b1100, 1'b0, 1'b0, 4'b0000);
    chk("gt_pass", 16'(exec_en), 16'h1);
    drive(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0000);
    chk("lt_fail", 16'(exec_en), 16'h0);
    drive(1'b1, 4'b1101, 1'b0, 1'b0, 4'b0000);
    chk("le_fail", 16'(exec_en), 16'h0);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000);
    chk("nv_fail", 16'(exec_en), 16'h0);
    // failing condition with s_bit must not touch flags
    drive(1'b1, 4'b1011, 1'b1, 1'b0, 4'b1111);
    tick();
    chk("fail_s_sr_kept", 16'(sr_out), 16'h3);
    chk("fail_s_squash_cnt", 16'(squash_count), 16'h2);
    chk("t2_exec_cnt", 16'(exec_count), 16'h4);

    // Test 3: BAL, then two squashed ADDS during FLUSH
    drive(1'b1, 4'b1110, 1'b0, 1'b1, 4'b0000);
    chk("bal_branch_taken", 16'(branch_taken), 16'h1);
    chk("bal_flush_c0", 16'(flush), 16'h1);
    tick();
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0100);
    chk("flush_c1", 16'(flush), 16'h1);
    chk("adds_c1_squashed", 16'(exec_en), 16'h0);
    chk("adds_c1_no_branch", 16'(branch_taken), 16'h0);
    tick();
    chk("flush_c2", 16'(flush), 16'h1);
    chk("adds_c2_squashed", 16'(exec_en), 16'h0);
    tick();
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 4'b0000);
    chk("flush_c3", 16'(flush), 16'h0);
    chk("t3_sr_kept", 16'(sr_out), 16'h3);
    chk("t3_squash_cnt", 16'(squash_count), 16'h4);
    chk("t3_exec_cnt", 16'(exec_count), 16'h5);
    tick();
    chk("invalid_no_count", 16'(squash_count), 16'h4);

    // Test 4: BAL with s_bit, then freeze for 3 cycles inside FLUSH
    drive(1'b1, 4'b1110, 1'b1, 1'b1, 4'b0001);
    tick();
    chk("bal_s_sr", 16'(sr_out), 16'h1);
    freeze = 1'b1;
    drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b1111);
    chk("frz_exec_en", 16'(exec_en), 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("frz_flush", 16'(flush), 16'h1);
      tick();
    end
    chk("frz_sr", 16'(sr_out), 16'h1);
    chk("frz_exec_cnt", 16'(exec_count), 16'h6);
    chk("frz_squash_cnt", 16'(squash_count), 16'h4);
    freeze = 1'b0;
    #1;
    chk("post_frz_flush_1", 16'(flush), 16'h1);
    chk("post_frz_squash_1", 16'(exec_en), 16'h0);
    tick();
    chk("post_frz_flush_2", 16'(flush), 16'h1);
    tick();
    chk("post_frz_flush_exit", 16'(flush), 16'h0);
    chk("t4_squash_cnt", 16'(squash_count), 16'h6);
    chk("t4_sr", 16'(sr_out), 16'h1);

    // Test 5: saturation of exec_count at 15
    drive(1'b1, 4'b1110, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    chk("exec_cnt_sat", 16'(exec_count), 16'hF);
    chk("sat_exec_en", 16'(exec_en), 16'h1);
    chk("sat_squash_cnt", 16'(squash_count), 16'h6);

    // Test 6: reset while frozen in FLUSH
    drive(1'b1, 4'b1110, 1'b1, 1'b1, 4'b1010);
    tick();
    freeze = 1'b1;
    drive(1'b0, 4'b1110, 1'b0, 1'b0, 4'b0000);
    chk("pre_rst_flush", 16'(flush), 16'h1);
    chk("pre_rst_sr", 16'(sr_out), 16'hA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    freeze = 1'b0;
    #1;
    chk("rst_flush", 16'(flush), 16'h0);
    chk("rst_sr", 16'(sr_out), 16'h0);
    chk("rst_exec_cnt", 16'(exec_count), 16'h0);
    chk("rst_squash_cnt", 16'(squash_count), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
